// File: rtl/mem_wb_elastic.sv
// mem_wb_elastic: MEM/WB register with valid/ready handshake and a one-entry skid buffer.
// Define MEM_WB_PERF_EN to add a saturating stall_count output.
module mem_wb_elastic #(
  parameter int S_WB      = 2,
  parameter int SIZE_DATA = 32,
  parameter int SIZE_ADDR = 5,
  parameter int COUNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
`ifdef MEM_WB_PERF_EN
  output logic [COUNT_W-1:0]   stall_count,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [S_WB-1:0]      WB,
  input  logic [SIZE_DATA-1:0] DatoLeido,
  input  logic [SIZE_DATA-1:0] direccion,
  input  logic [SIZE_ADDR-1:0] direccionRegistro,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [S_WB-1:0]      WB_out,
  output logic [SIZE_DATA-1:0] datoLeido_out,
  output logic [SIZE_DATA-1:0] direccion_out,
  output logic [SIZE_ADDR-1:0] direccionRegistro_out,
  output logic                 wb_reg_write,
  output logic [SIZE_DATA-1:0] wb_data
);
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
  state_t state;
  logic [S_WB-1:0]      skid_wb;
  logic [SIZE_DATA-1:0] skid_dato, skid_dir;
  logic [SIZE_ADDR-1:0] skid_reg;
  logic accept, take;
  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;
  assign wb_reg_write = out_valid & WB_out[1];
  assign wb_data      = WB_out[0] ? datoLeido_out : direccion_out;
  // in_ready/out_valid are registered copies of the state so out_ready never reaches in_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= EMPTY;
      in_ready              <= 1'b1;
      out_valid             <= 1'b0;
      WB_out                <= '0;
      datoLeido_out         <= '0;
      direccion_out         <= '0;
      direccionRegistro_out <= '0;
      skid_wb               <= '0;
      skid_dato             <= '0;
      skid_dir              <= '0;
      skid_reg              <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      WB_out    <= '0;
    end else if (state == FULL) begin
      if (take) begin
        state                 <= BUSY;
        in_ready              <= 1'b1;
        WB_out                <= skid_wb;
        datoLeido_out         <= skid_dato;
        direccion_out         <= skid_dir;
        direccionRegistro_out <= skid_reg;
      end
    end else if (accept && (state == EMPTY || take)) begin
      state                 <= BUSY;
      out_valid             <= 1'b1;
      WB_out                <= WB;
      datoLeido_out         <= DatoLeido;
      direccion_out         <= direccion;
      direccionRegistro_out <= direccionRegistro;
    end else if (accept) begin
      state     <= FULL;
      in_ready  <= 1'b0;
      skid_wb   <= WB;
      skid_dato <= DatoLeido;
      skid_dir  <= direccion;
      skid_reg  <= direccionRegistro;
    end else if (take) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
    end
  end
`ifdef MEM_WB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_count <= '0;
    else if (out_valid && !out_ready && stall_count != '1) stall_count <= stall_count + 1'b1;
  end
`else
  logic [COUNT_W-1:0] unused_count;
  assign unused_count = '0;
`endif
endmodule

// File: tb/tb_mem_wb_elastic.sv
// tb_mem_wb_elastic: directed and random stimulus against a queue-based FIFO model of mem_wb_elastic.
module tb_mem_wb_elastic;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [1:0] WB = '0;
  logic [31:0] DatoLeido = '0, direccion = '0;
  logic [4:0] direccionRegistro = '0;
  logic in_ready, out_valid, wb_reg_write;
  logic [1:0] WB_out;
  logic [31:0] datoLeido_out, direccion_out, wb_data;
  logic [4:0] direccionRegistro_out;
`ifdef MEM_WB_PERF_EN
  logic [15:0] stall_count;
  logic [15:0] sc_model = '0;
`endif
  typedef struct packed {logic [1:0] wb; logic [31:0] d; logic [31:0] a; logic [4:0] r;} ent_t;
  ent_t q[$];
  int n_chk = 0, n_fail = 0;
  bit flushed = 0;

  mem_wb_elastic dut (
    .clk(clk), .rst(rst), .flush(flush),
`ifdef MEM_WB_PERF_EN
    .stall_count(stall_count),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .WB(WB), .DatoLeido(DatoLeido),
    .direccion(direccion), .direccionRegistro(direccionRegistro),
    .out_valid(out_valid), .out_ready(out_ready), .WB_out(WB_out),
    .datoLeido_out(datoLeido_out), .direccion_out(direccion_out),
    .direccionRegistro_out(direccionRegistro_out),
    .wb_reg_write(wb_reg_write), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic f, input ent_t e);
    in_valid = v; out_ready = r; flush = f;
    {WB, DatoLeido, direccion, direccionRegistro} = e;
  endtask

  task automatic compare;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("WB_out", WB_out, q[0].wb);
      chk("datoLeido_out", datoLeido_out, q[0].d);
      chk("direccion_out", direccion_out, q[0].a);
      chk("dirReg_out", direccionRegistro_out, q[0].r);
      chk("wb_reg_write", wb_reg_write, q[0].wb[1]);
      chk("wb_data", wb_data, q[0].wb[0] ? q[0].d : q[0].a);
    end else chk("wb_reg_write_idle", wb_reg_write, 0);
    if (flushed) chk("WB_out_flush", WB_out, 0);
`ifdef MEM_WB_PERF_EN
    chk("stall_count", stall_count, sc_model);
`endif
  endtask

  task automatic step;
    bit acc, tk;
    ent_t cur;
    @(posedge clk);
    cur = {WB, DatoLeido, direccion, direccionRegistro};
    acc = in_valid && q.size() < 2;
    tk = out_ready && q.size() > 0;
`ifdef MEM_WB_PERF_EN
    if (q.size() > 0 && !out_ready && sc_model != 16'hFFFF) sc_model++;
`endif
    flushed = flush;
    if (flush) q.delete();
    else begin
      if (tk) void'(q.pop_front());
      if (acc) q.push_back(cur);
    end
    @(negedge clk);
    compare();
  endtask

  function automatic ent_t rnd_ent();
    return {2'($urandom), 32'($urandom), 32'($urandom), 5'($urandom)};
  endfunction

  ent_t e1, e2, e3;
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    rst = 0;
    drive(1, 1, 0, {2'b11, 32'hA5A5_0001, 32'h0000_0040, 5'd8});
    step();
    chk("first_valid", out_valid, 1);
    chk("first_regwrite", wb_reg_write, 1);
    chk("first_data", wb_data, 32'hA5A5_0001);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, {2'b01, 32'(100 + i), 32'(i), 5'(i)});
      step();
      chk("stream_order", datoLeido_out, 100 + i);
    end
    drive(1, 1, 0, {2'b10, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3});
    step();
    chk("sel_alu", wb_data, 32'h1234_5678);
    chk("sel_regwrite", wb_reg_write, 1);
    drive(1, 1, 0, {2'b00, 32'h1, 32'h2, 5'd4});
    step();
    chk("no_regwrite", wb_reg_write, 0);
    drive(0, 1, 0, '0);
    step();
    e1 = rnd_ent(); e2 = rnd_ent(); e3 = rnd_ent();
    drive(1, 0, 0, e1); step();
    drive(1, 0, 0, e2); step();
    chk("bp_in_ready", in_ready, 0);
    drive(1, 0, 0, e3); step();
    chk("bp_hold_e1", direccion_out, e1.a);
    drive(1, 1, 0, e3); step();
    chk("bp_e2", direccion_out, e2.a);
    step();
    chk("bp_e3", direccion_out, e3.a);
    drive(0, 1, 0, '0); step();
    drive(1, 0, 0, rnd_ent()); step(); step();
    chk("full_before_flush", in_ready, 0);
    drive(1, 0, 1, rnd_ent()); step();
    chk("flush_valid", out_valid, 0);
    chk("flush_wb", WB_out, 0);
    chk("flush_ready", in_ready, 1);
    drive(0, 0, 0, '0); step();
    chk("flush_not_captured", out_valid, 0);
    drive(1, 0, 0, rnd_ent()); step(); step();
    #2 rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_wb", WB_out, 0);
    chk("arst_data", wb_data, 0);
    chk("arst_dir", {datoLeido_out, direccion_out}, 0);
    chk("arst_reg", direccionRegistro_out, 0);
    q.delete();
`ifdef MEM_WB_PERF_EN
    sc_model = '0;
`endif
    @(negedge clk);
    rst = 0;
    e1 = rnd_ent();
    drive(1, 1, 0, e1); step();
    chk("post_rst_first", direccion_out, e1.a);
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, rnd_ent());
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
